// File: rtl/egr_rrq_pkg.sv
// Shared types for the egress read-request path: client ids, payload
// fields and the mesh read-request record.
package egr_rrq_pkg;

   localparam int RRQ_N_CLIENTS = 3;
   localparam int RRQ_ADDR_W    = 20;
   localparam int RRQ_TAG_W     = 8;
   localparam int RRQ_MAX_OUTST = 16;
   localparam int RRQ_CID_W     = $clog2(RRQ_N_CLIENTS);

   localparam int CID_CPB = 0;
   localparam int CID_TMU = 1;
   localparam int CID_PRC = 2;

   typedef logic [RRQ_ADDR_W-1:0] rrq_addr_t;
   typedef logic [RRQ_TAG_W-1:0]  rrq_tag_t;
   typedef logic [RRQ_CID_W-1:0]  rrq_cid_t;

   typedef struct packed {
      rrq_addr_t addr;
      rrq_tag_t  tag;
      rrq_cid_t  cid;
   } rrq_req_t;

endpackage

// File: rtl/egr_rr_pick.sv
// Generic N-way round-robin picker: one-hot grant of the first eligible
// index at or above ptr, wrapping. Purely combinational.
module egr_rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   logic found;

   // Outer loop walks priority order from ptr; inner loop keeps all
   // bit selects constant after unrolling.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && eligible[i] && (i == ((int'(ptr) + k) % N))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/egr_rrq_arb.sv
// Egress read-request arbiter: round-robin merge of client read requests into
// one registered mesh request, with per-client outstanding limits. Optional perf counters: EGR_RRQ_ARB_PERF_EN.
module egr_rrq_arb
   import egr_rrq_pkg::*;
#(
   parameter int N_CLIENTS = RRQ_N_CLIENTS,
   parameter int ADDR_W    = RRQ_ADDR_W,
   parameter int TAG_W     = RRQ_TAG_W,
   parameter int MAX_OUTST = RRQ_MAX_OUTST,
   parameter int CNT_W     = $clog2(MAX_OUTST + 1),
   parameter int CID_W     = $clog2(N_CLIENTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CLIENTS-1:0]        req_valid,
   output logic [N_CLIENTS-1:0]        req_ready,
   input  logic [N_CLIENTS*ADDR_W-1:0] req_addr,
   input  logic [N_CLIENTS*TAG_W-1:0]  req_tag,
   output logic                        mrq_valid,
   input  logic                        mrq_ready,
   output logic [ADDR_W-1:0]           mrq_addr,
   output logic [TAG_W-1:0]            mrq_tag,
   output logic [CID_W-1:0]            mrq_cid,
   input  logic                        rsp_done_valid,
   input  logic [CID_W-1:0]            rsp_done_cid,
   output logic [N_CLIENTS*CNT_W-1:0]  outst_cnt,
   output logic                        err_underflow
`ifdef EGR_RRQ_ARB_PERF_EN
   ,
   output logic [N_CLIENTS*32-1:0]     grant_cnt,
   output logic [31:0]                 stall_cnt
`endif
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
      logic [CID_W-1:0]  cid;
   } slot_t;

   logic                 slot_free;
   logic [N_CLIENTS-1:0] eligible;
   logic [N_CLIENTS-1:0] grant;
   logic [N_CLIENTS-1:0] underflow;
   logic [CID_W-1:0]     ptr;
   logic [CID_W-1:0]     gidx;
   logic                 cid_bad;
   slot_t                slot;
   slot_t                pick;

   assign slot_free = !mrq_valid || mrq_ready;
   assign cid_bad   = rsp_done_valid && (32'(rsp_done_cid) >= N_CLIENTS);

   egr_rr_pick #(.N(N_CLIENTS), .PTR_W(CID_W)) u_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (grant)
   );

   assign req_ready = grant;

   always_comb begin
      gidx = '0;
      pick = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (grant[i]) begin
            gidx      = CID_W'(i);
            pick.addr = req_addr[i*ADDR_W +: ADDR_W];
            pick.tag  = req_tag[i*TAG_W +: TAG_W];
            pick.cid  = CID_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mrq_valid <= 1'b0;
         slot      <= '0;
         ptr       <= '0;
      end else if (slot_free) begin
         mrq_valid <= |grant;
         if (|grant) begin
            slot <= pick;
            ptr  <= (gidx == CID_W'(N_CLIENTS - 1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   assign mrq_addr = slot.addr;
   assign mrq_tag  = slot.tag;
   assign mrq_cid  = slot.cid;

   // A grant and a release on the same client cancel; a release at zero
   // saturates and is flagged.
   for (genvar i = 0; i < N_CLIENTS; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      logic             inc;
      logic             dec;

      assign inc          = grant[i];
      assign dec          = rsp_done_valid && (rsp_done_cid == CID_W'(i));
      assign underflow[i] = dec && (cnt == '0);
      assign eligible[i]  = slot_free && req_valid[i] && (cnt < CNT_W'(MAX_OUTST));
      assign outst_cnt[i*CNT_W +: CNT_W] = cnt;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
         end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
         end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
      end else if ((|underflow) || cid_bad) begin
         err_underflow <= 1'b1;
      end
   end

`ifdef EGR_RRQ_ARB_PERF_EN
   for (genvar i = 0; i < N_CLIENTS; i++) begin : g_perf
      always_ff @(posedge clk) begin
         if (rst) begin
            grant_cnt[i*32 +: 32] <= '0;
         end else if (grant[i]) begin
            grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (mrq_valid && !mrq_ready) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_egr_rrq_arb.sv
// Bench for egr_rrq_arb: a behavioural reference model plus a scoreboard of
// expected mesh requests, and scenario tasks with their own targeted checks.
module tb_egr_rrq_arb;
   import egr_rrq_pkg::*;

   localparam int N  = 3;
   localparam int AW = 20;
   localparam int TW = 8;
   localparam int MO = 16;
   localparam int CW = 5;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [AW-1:0]   a [N];
   logic [TW-1:0]   tg [N];
   logic [N*AW-1:0] req_addr;
   logic [N*TW-1:0] req_tag;
   logic            mrq_valid;
   logic            mrq_ready = 1'b1;
   logic [AW-1:0]   mrq_addr;
   logic [TW-1:0]   mrq_tag;
   logic [IW-1:0]   mrq_cid;
   logic            rsp_done_valid = 1'b0;
   logic [IW-1:0]   rsp_done_cid = '0;
   logic [N*CW-1:0] outst_cnt;
   logic            err_underflow;
`ifdef EGR_RRQ_ARB_PERF_EN
   logic [N*32-1:0] grant_cnt;
   logic [31:0]     stall_cnt;
`endif

   always #5 clk = ~clk;

   assign req_addr = {a[2], a[1], a[0]};
   assign req_tag  = {tg[2], tg[1], tg[0]};

   egr_rrq_arb dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_tag        (req_tag),
      .mrq_valid      (mrq_valid),
      .mrq_ready      (mrq_ready),
      .mrq_addr       (mrq_addr),
      .mrq_tag        (mrq_tag),
      .mrq_cid        (mrq_cid),
      .rsp_done_valid (rsp_done_valid),
      .rsp_done_cid   (rsp_done_cid),
      .outst_cnt      (outst_cnt),
      .err_underflow  (err_underflow)
`ifdef EGR_RRQ_ARB_PERF_EN
      ,
      .grant_cnt      (grant_cnt),
      .stall_cnt      (stall_cnt)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   bit started = 1'b0;

   // Reference model state
   int       m_ptr = 0;
   int       m_cnt [N] = '{0, 0, 0};
   bit       m_vld = 1'b0;
   bit       m_err = 1'b0;
   logic [N-1:0] m_last_g = '0;
   rrq_req_t sb [$];

   function automatic logic [N-1:0] mgrant();
      logic [N-1:0] g;
      int idx;
      g = '0;
      if (m_vld && !mrq_ready) return g;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (req_valid[idx] && m_cnt[idx] < MO) begin
            g[idx] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   always @(posedge clk) begin : model
      logic [N-1:0] g;
      rrq_req_t e;
      bit inc, dec;
      g = mgrant();
      if (rst) begin
         m_ptr = 0;
         m_vld = 1'b0;
         m_err = 1'b0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
         sb.delete();
         m_last_g = '0;
      end else begin
         if (!m_vld || mrq_ready) m_vld = (g != '0);
         for (int i = 0; i < N; i++) begin
            if (g[i]) begin
               e.addr = a[i];
               e.tag  = tg[i];
               e.cid  = IW'(i);
               sb.push_back(e);
               m_ptr = (i + 1) % N;
            end
            inc = g[i];
            dec = rsp_done_valid && (int'(rsp_done_cid) == i);
            if (dec && m_cnt[i] == 0) m_err = 1'b1;
            if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
         end
         if (rsp_done_valid && int'(rsp_done_cid) >= N) m_err = 1'b1;
         m_last_g = g;
      end
   end

   // Continuous checking against the model; scoreboard pops on each transfer.
   always @(negedge clk) begin : monitor
      rrq_req_t e;
      logic [N-1:0] eg;
      if (started && !rst) begin
         eg = mgrant();
         vectors++;
         if (req_ready !== eg) begin
            miscompares++;
            $display("FAIL mon_req_ready: got %b want %b", req_ready, eg);
         end
         vectors++;
         if (mrq_valid !== m_vld) begin
            miscompares++;
            $display("FAIL mon_mrq_valid: got %b want %b", mrq_valid, m_vld);
         end
         for (int i = 0; i < N; i++) begin
            vectors++;
            if (outst_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin
               miscompares++;
               $display("FAIL mon_cnt%0d: got %0d want %0d", i, outst_cnt[i*CW +: CW], m_cnt[i]);
            end
         end
         vectors++;
         if (err_underflow !== m_err) begin
            miscompares++;
            $display("FAIL mon_err: got %b want %b", err_underflow, m_err);
         end
         if (mrq_valid && mrq_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_empty: got transfer cid %0d want none", mrq_cid);
            end else begin
               e = sb.pop_front();
               if (mrq_addr !== e.addr || mrq_tag !== e.tag || mrq_cid !== e.cid) begin
                  miscompares++;
                  $display("FAIL sb_payload: got %h/%h/%0d want %h/%h/%0d",
                           mrq_addr, mrq_tag, mrq_cid, e.addr, e.tag, e.cid);
               end
            end
         end
      end
   end

   // Advance one cycle; clients whose request was taken present a new payload.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (m_last_g[i]) begin
            a[i]  = a[i] + 20'h00101;
            tg[i] = tg[i] + 8'h11;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      rsp_done_valid = 1'b0;
      mrq_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      started = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vectors++;
      if (mrq_valid !== 1'b0 || mrq_addr !== '0 || mrq_tag !== '0 || mrq_cid !== '0) begin
         miscompares++;
         $display("FAIL reset_mrq: got %b %h %h %0d want 0 0 0 0", mrq_valid, mrq_addr, mrq_tag, mrq_cid);
      end
      vectors++;
      if (outst_cnt !== '0 || err_underflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_cnt: got %h err %b want 0 err 0", outst_cnt, err_underflow);
      end
   endtask

   task automatic test_single();
      do_reset();
      a[CID_TMU]  = 20'h00ABC;
      tg[CID_TMU] = 8'h5A;
      req_valid   = 3'b010;
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b010) begin
         miscompares++;
         $display("FAIL single_ready: got %b want 010", req_ready);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      vectors++;
      if (mrq_valid !== 1'b1 || mrq_cid !== 2'd1 || mrq_addr !== 20'h00ABC || mrq_tag !== 8'h5A) begin
         miscompares++;
         $display("FAIL single_mrq: got %b %0d %h %h want 1 1 00abc 5a", mrq_valid, mrq_cid, mrq_addr, mrq_tag);
      end
      vectors++;
      if (outst_cnt[1*CW +: CW] !== 5'd1) begin
         miscompares++;
         $display("FAIL single_cnt: got %0d want 1", outst_cnt[1*CW +: CW]);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      do_reset();
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         vectors++;
         if (req_ready !== exp_seq[k]) begin
            miscompares++;
            $display("FAIL rr_order%0d: got %b want %b", k, req_ready, exp_seq[k]);
         end
         tick();
      end
      req_valid = '0;
      @(negedge clk);
      vectors++;
      if (outst_cnt !== {5'd2, 5'd2, 5'd2}) begin
         miscompares++;
         $display("FAIL rr_cnt: got %h want 2,2,2", outst_cnt);
      end
      tick();
   endtask

   task automatic test_outst_limit();
      int n = 0;
      do_reset();
      req_valid = 3'b100;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready[CID_PRC]) n++;
         tick();
      end
      vectors++;
      if (n != 16) begin
         miscompares++;
         $display("FAIL limit_grants: got %0d want 16", n);
      end
      rsp_done_valid = 1'b1;
      rsp_done_cid   = 2'd2;
      @(negedge clk);
      vectors++;
      if (req_ready[CID_PRC] !== 1'b0 || outst_cnt[2*CW +: CW] !== 5'd16) begin
         miscompares++;
         $display("FAIL limit_block: got rdy %b cnt %0d want 0 16", req_ready[CID_PRC], outst_cnt[2*CW +: CW]);
      end
      tick();
      rsp_done_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready[CID_PRC] !== 1'b1 || outst_cnt[2*CW +: CW] !== 5'd15) begin
         miscompares++;
         $display("FAIL limit_release: got rdy %b cnt %0d want 1 15", req_ready[CID_PRC], outst_cnt[2*CW +: CW]);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      vectors++;
      if (outst_cnt[2*CW +: CW] !== 5'd16) begin
         miscompares++;
         $display("FAIL limit_refill: got %0d want 16", outst_cnt[2*CW +: CW]);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] exp_addr;
      logic [TW-1:0] exp_tag;
      do_reset();
      req_valid = 3'b011;
      exp_addr  = a[0];
      exp_tag   = tg[0];
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b001) begin
         miscompares++;
         $display("FAIL bp_first: got %b want 001", req_ready);
      end
      tick();
      mrq_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++;
         if (req_ready !== 3'b000 || mrq_valid !== 1'b1 || mrq_addr !== exp_addr ||
             mrq_tag !== exp_tag || mrq_cid !== 2'd0 || outst_cnt !== {5'd0, 5'd0, 5'd1}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got rdy %b v %b %h %h %0d cnt %h want 000 1 %h %h 0 cnt 001",
                     k, req_ready, mrq_valid, mrq_addr, mrq_tag, mrq_cid, outst_cnt, exp_addr, exp_tag);
         end
         @(posedge clk);
         #1;
      end
`ifdef EGR_RRQ_ARB_PERF_EN
      @(negedge clk);
      vectors++;
      if (stall_cnt !== 32'd5) begin
         miscompares++;
         $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt);
      end
`endif
      mrq_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b010) begin
         miscompares++;
         $display("FAIL bp_resume: got %b want 010", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_simultaneous();
      do_reset();
      req_valid = 3'b001;
      repeat (3) tick();
      rsp_done_valid = 1'b1;
      rsp_done_cid   = 2'd0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b001) begin
         miscompares++;
         $display("FAIL sim_grant: got %b want 001", req_ready);
      end
      tick();
      rsp_done_valid = 1'b0;
      req_valid = '0;
      @(negedge clk);
      vectors++;
      if (outst_cnt[0 +: CW] !== 5'd3) begin
         miscompares++;
         $display("FAIL sim_cnt: got %0d want 3", outst_cnt[0 +: CW]);
      end
      rsp_done_valid = 1'b1;
      rsp_done_cid   = 2'd1;
      tick();
      rsp_done_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (err_underflow !== 1'b1 || outst_cnt[1*CW +: CW] !== 5'd0) begin
         miscompares++;
         $display("FAIL sim_underflow: got err %b cnt %0d want 1 0", err_underflow, outst_cnt[1*CW +: CW]);
      end
      repeat (3) tick();
      @(negedge clk);
      vectors++;
      if (err_underflow !== 1'b1) begin
         miscompares++;
         $display("FAIL sim_sticky: got %b want 1", err_underflow);
      end
      do_reset();
      @(negedge clk);
      vectors++;
      if (err_underflow !== 1'b0) begin
         miscompares++;
         $display("FAIL sim_err_clr: got %b want 0", err_underflow);
      end
      rsp_done_valid = 1'b1;
      rsp_done_cid   = 2'd3;
      tick();
      rsp_done_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (err_underflow !== 1'b1 || outst_cnt !== '0) begin
         miscompares++;
         $display("FAIL sim_bad_cid: got err %b cnt %h want 1 0", err_underflow, outst_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 3'b010;
      repeat (7) tick();
      req_valid = 3'b100;
      repeat (2) tick();
      req_valid = 3'b001;
      repeat (4) tick();
      mrq_ready = 1'b0;
      req_valid = '0;
      @(negedge clk);
      vectors++;
      if (mrq_valid !== 1'b1 || outst_cnt !== {5'd2, 5'd7, 5'd4}) begin
         miscompares++;
         $display("FAIL mid_setup: got v %b cnt %h want 1 cnt 2,7,4", mrq_valid, outst_cnt);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mrq_ready = 1'b1;
      req_valid = 3'b111;
      @(negedge clk);
      vectors++;
      if (mrq_valid !== 1'b0 || outst_cnt !== '0 || req_ready !== 3'b001) begin
         miscompares++;
         $display("FAIL mid_after: got v %b cnt %h rdy %b want 0 0 001", mrq_valid, outst_cnt, req_ready);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      vectors++;
      if (mrq_valid !== 1'b1 || mrq_cid !== 2'd0) begin
         miscompares++;
         $display("FAIL mid_regrant: got v %b cid %0d want 1 0", mrq_valid, mrq_cid);
      end
      tick();
   endtask

   task automatic test_drain();
      req_valid = '0;
      mrq_ready = 1'b1;
      repeat (3) tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain_sb: got %0d pending want 0", sb.size());
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         a[i]  = AW'(20'h10000 * (i + 1));
         tg[i] = TW'(8'h10 * (i + 1));
      end
      test_reset();
      test_single();
      test_round_robin();
      test_outst_limit();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule

// File: doc/egr_rrq_arb.md
Name: egr_rrq_arb

Overview:
- Egress read-request arbiter, directly upstream of the mesh read interface.
- Merges the read-request streams from the Clean Pointer Broker (client 0), the Tag Management Unit (client 1) and the Packet Read Controller (client 2) into one registered mesh read-request stream.
- Round-robin arbitration across clients.
- Each client is limited to a fixed number of outstanding reads; a client's count is released when the mesh read interface reports that client's response delivered.

Parameters:
- N_CLIENTS, 3, number of requesting clients (client id = index).
- ADDR_W, 20, mesh read address width.
- TAG_W, 8, requester tag width, passed through untouched.
- MAX_OUTST, 16, maximum outstanding reads per client (1..2^CNT_W-1).
- CNT_W, $clog2(MAX_OUTST+1), outstanding-counter width (derived).
- CID_W, $clog2(N_CLIENTS), client-id width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  N_CLIENTS  per-client request valid
- req_ready  out  N_CLIENTS  per-client request accept
- req_addr  in  N_CLIENTS*ADDR_W  per-client address, client i at [i*ADDR_W +: ADDR_W]
- req_tag  in  N_CLIENTS*TAG_W  per-client tag
- mrq_valid  out  1  mesh read request valid (registered)
- mrq_ready  in  1  mesh read request accept
- mrq_addr  out  ADDR_W  granted address
- mrq_tag  out  TAG_W  granted tag
- mrq_cid  out  CID_W  granted client id
- rsp_done_valid  in  1  one response delivered back to a client
- rsp_done_cid  in  CID_W  client whose response was delivered
- outst_cnt  out  N_CLIENTS*CNT_W  per-client outstanding count
- err_underflow  out  1  sticky error: rsp_done for a client whose count is 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - mrq_valid=0; mrq_addr, mrq_tag and mrq_cid = 0.
  - All outst_cnt = 0; err_underflow = 0.
  - RR pointer = 0.
- Handshakes:
  - Both sides use valid/ready.
  - A request transfers when valid && ready.
  - A valid, once raised, is held with stable payload until it transfers.
- Eligibility: eligible[i] = req_valid[i] && outst_cnt[i] < MAX_OUTST.
- Output slot:
  - Single register; slot_free = !mrq_valid || mrq_ready.
- Grant:
  - Only when slot_free.
  - One-hot pick of the first eligible client searching from the RR pointer upward, with wrap-around.
  - req_ready[i] = grant[i], combinational from req_valid, the counters, mrq_valid and mrq_ready.
- Grant side effects (next edge):
  - mrq_valid<=1, and the payload registers load from the granted client.
  - RR pointer <= (granted index + 1) mod N_CLIENTS.
- No grant while the slot is free: mrq_valid<=0.
- Latency:
  - Accepted at edge t, mrq_valid is visible from t+1.
  - Back-to-back throughput of 1 per cycle while mrq_ready=1.
- Counter updates:
  - outst_cnt[i] increments on grant[i].
  - outst_cnt[i] decrements on rsp_done_valid with rsp_done_cid==i.
  - Both in the same cycle: count unchanged.
  - Different clients in the same cycle: both updates apply.
- Underflow:
  - Decrement at 0 holds the count at 0 and sets err_underflow.
  - err_underflow clears only on rst.
- rsp_done_cid >= N_CLIENTS: ignored and sets err_underflow.
- A client at MAX_OUTST is skipped without moving the pointer past it unfairly; the pointer advances only on grants.
- A decrement in cycle t makes the client eligible at t+1; there is no same-cycle bypass.
- Reset mid-operation: any pending mrq request is dropped and all counters zero. Upstream clients re-issue.

Optional Feature:
- Macro: EGR_RRQ_ARB_PERF_EN.
- When defined:
  - Adds output grant_cnt (N_CLIENTS*32): a per-client count of grants, wrapping at 2^32.
  - Adds output stall_cnt (32): counts cycles with mrq_valid && !mrq_ready.
  - All reset to 0.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package egr_rrq_pkg holds:
  - Client-id localparams CID_CPB=0, CID_TMU=1, CID_PRC=2.
  - Typedefs rrq_addr_t and rrq_tag_t.
  - Struct rrq_req_t {addr, tag, cid}.
- Sub-module egr_rr_pick: generic N-way round-robin one-hot picker (inputs eligible and ptr, output grant), reusable elsewhere in egress.

Test Plan:
- Single request: reset, then only client 1 requests, addr=0x00ABC, tag=0x5A.
  - req_ready[1]=1 at t.
  - mrq_valid=1, mrq_cid=1, addr=0x00ABC, tag=0x5A at t+1.
  - outst_cnt[1]=1.
- Round-robin order: all three clients hold valid and mrq_ready=1 for 6 cycles.
  - Grant order 0,1,2,0,1,2.
  - outst_cnt = 2,2,2.
- Outstanding limit: MAX_OUTST=16, client 2 streams 20 requests with no rsp_done.
  - 16 grants, then req_ready[2]=0.
  - One rsp_done (cid=2) re-enables it next cycle; count returns to 16.
- Backpressure: mrq_ready=0 for 5 cycles while clients 0 and 1 request.
  - mrq payload stable, no further grants, counts unchanged.
  - stall_cnt=5 with EGR_RRQ_ARB_PERF_EN.
- Simultaneous events:
  - Grant and rsp_done on client 0 in the same cycle: count unchanged at 3.
  - rsp_done on client 1 with count 0: err_underflow=1, stays set until rst.
- Reset mid-operation: assert rst for 1 cycle while mrq_valid=1 and counts are 4,7,2.
  - Next cycle: mrq_valid=0, all counts 0, pointer 0; the next grant goes to the lowest eligible client.
